// File: rtl/dsp_rdport.sv
// DSP-bus read responder: FIFO of accumulated words returned over xd on zcs2/xrd reads.
// Define DSP_RDPORT_STAT_EN to also decode the status (BASE+1) and count (BASE+2) registers.
`timescale 1ns/1ps
module dsp_rdport #(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [18:0] BASE_ADDR  = 19'h00100
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_zcs2,
  input  logic                  i_xrd,
  input  logic [18:0]           i_xa,
  input  logic                  i_wr_en,
  input  logic [15:0]           i_wr_data,
  input  logic                  i_clr,
  output logic [15:0]           o_xd_out,
  output logic                  o_xd_oe,
  output logic                  o_fifo_full,
  output logic                  o_fifo_empty,
  output logic                  o_ovf,
  output logic [DEPTH_LOG2:0]   o_rd_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] SEL_DATA = 2'd0;
  localparam logic [1:0] SEL_STAT = 2'd1;
  localparam logic [1:0] SEL_CNT  = 2'd2;

  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [1:0]            r_zcs2_s, r_xrd_s;
  logic                  r_rd_act_d;
  logic [1:0]            r_state, r_sel;
  logic                  r_xd_oe, r_had_word;
  logic [15:0]           r_xd_out;
  logic [15:0]           r_mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_ovf, r_unf;

  logic        w_rd_act, w_rd_rise;
  logic        w_hit_data, w_hit_stat, w_hit_cnt, w_hit_any;
  logic        w_full, w_empty, w_load, w_pop, w_push;
  logic [1:0]  w_sel_next;
  logic [8:0]  w_cnt9;
  logic [15:0] w_load_val;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_zcs2_s   <= 2'b11;
      r_xrd_s    <= 2'b11;
      r_rd_act_d <= 1'b0;
    end else begin
      r_zcs2_s   <= {r_zcs2_s[0], i_zcs2};
      r_xrd_s    <= {r_xrd_s[0], i_xrd};
      r_rd_act_d <= w_rd_act;
    end
  end

  assign w_rd_act  = ~r_zcs2_s[1] & ~r_xrd_s[1];
  assign w_rd_rise = w_rd_act & ~r_rd_act_d;

  assign w_hit_data = (i_xa == BASE_ADDR);
`ifdef DSP_RDPORT_STAT_EN
  assign w_hit_stat = (i_xa == BASE_ADDR + 19'd1);
  assign w_hit_cnt  = (i_xa == BASE_ADDR + 19'd2);
`else
  assign w_hit_stat = 1'b0;
  assign w_hit_cnt  = 1'b0;
`endif
  assign w_hit_any  = w_hit_data | w_hit_stat | w_hit_cnt;
  assign w_sel_next = w_hit_data ? SEL_DATA : (w_hit_stat ? SEL_STAT : SEL_CNT);

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_cnt9  = 9'(r_count);

  always_comb begin
    w_load_val = 16'h0000;
    case (w_sel_next)
      SEL_DATA: w_load_val = w_empty ? 16'h0000 : r_mem[r_rd_ptr];
      SEL_STAT: w_load_val = {r_ovf, r_unf, w_full, w_empty, 3'b000, w_cnt9};
      default:  w_load_val = 16'(r_count);
    endcase
  end

  assign w_load = (r_state == S_IDLE) && w_rd_rise && w_hit_any;
  // had_word is dropped by clr so a cleared FIFO is never popped by a read already in flight
  assign w_pop  = (r_state == S_DONE) && (r_sel == SEL_DATA) && r_had_word;
  assign w_push = i_wr_en && (!w_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_sel      <= SEL_DATA;
      r_xd_oe    <= 1'b0;
      r_xd_out   <= 16'h0000;
      r_had_word <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_state    <= S_DRIVE;
            r_xd_oe    <= 1'b1;
            r_sel      <= w_sel_next;
            r_xd_out   <= w_load_val;
            r_had_word <= w_hit_data && !w_empty;
          end
        end
        S_DRIVE: begin
          if (!w_rd_act) begin
            r_state <= S_DONE;
            r_xd_oe <= 1'b0;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: begin
          r_state <= S_IDLE;
          r_xd_oe <= 1'b0;
        end
      endcase
      if (i_clr) r_had_word <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_clr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // a fresh event in the clearing cycle wins over the status-read clear
      if ((r_state == S_DONE) && (r_sel == SEL_STAT)) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end
      if (w_load && w_hit_data && w_empty) r_unf <= 1'b1;
      if (i_wr_en && w_full && !w_pop)     r_ovf <= 1'b1;
    end
  end

  assign o_xd_out     = r_xd_out;
  assign o_xd_oe      = r_xd_oe;
  assign o_fifo_full  = w_full;
  assign o_fifo_empty = w_empty;
  assign o_ovf        = r_ovf;
  assign o_rd_count   = r_count;

endmodule

// File: tb/tb_dsp_rdport.sv
// Scoreboard bench for dsp_rdport: queue-based FIFO model, randomized pushes and DSP reads.
`timescale 1ns/1ps
module tb_dsp_rdport;
  localparam int          DL    = 8;
  localparam int          DEPTH = 256;
  localparam logic [18:0] BASE  = 19'h00100;
`ifdef DSP_RDPORT_STAT_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  logic        clk, rst_n, zcs2, xrd, wr_en, clr;
  logic [18:0] xa;
  logic [15:0] wr_data, xd_out;
  logic        xd_oe, fifo_full, fifo_empty, ovf;
  logic [DL:0] rd_count;

  dsp_rdport #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_zcs2(zcs2), .i_xrd(xrd), .i_xa(xa),
    .i_wr_en(wr_en), .i_wr_data(wr_data), .i_clr(clr),
    .o_xd_out(xd_out), .o_xd_oe(xd_oe), .o_fifo_full(fifo_full),
    .o_fifo_empty(fifo_empty), .o_ovf(ovf), .o_rd_count(rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int oe_rises = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mdl[$];
  bit m_ovf = 0, m_unf = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // monitor: each new drive window pops one expected word; the word must then hold
  logic        prev_oe = 1'b0;
  logic [15:0] held = '0;
  always @(negedge clk) begin
    if (xd_oe && !prev_oe) begin
      oe_rises++;
      held = xd_out;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_drive: got xd_out %0h with no read outstanding", xd_out);
      end else chk("xd_out", xd_out, exp_q.pop_front());
    end else if (xd_oe && prev_oe) chk("xd_hold", xd_out, held);
    prev_oe <= xd_oe;
  end

  task automatic check_flags(input string tag);
    chk({tag, ":rd_count"}, int'(rd_count), mdl.size());
    chk({tag, ":full"}, fifo_full, int'(mdl.size() == DEPTH));
    chk({tag, ":empty"}, fifo_empty, int'(mdl.size() == 0));
    chk({tag, ":ovf"}, ovf, m_ovf);
  endtask

  task automatic push(input logic [15:0] w);
    wr_en = 1'b1; wr_data = w;
    @(negedge clk);
    wr_en = 1'b0;
    if (mdl.size() == DEPTH) m_ovf = 1;
    else mdl.push_back(w);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    mdl.delete(); m_ovf = 0; m_unf = 0;
  endtask

  // predict the response at issue time, then run a full DSP read strobe
  task automatic dsp_read(input logic [18:0] addr, input bit push_at_done, input logic [15:0] pw);
    bit drives = 0;
    logic [15:0] e = '0;
    int lat = 0, r0, sz;
    bit seen = 0;
    sz = mdl.size();
    if (addr == BASE) begin
      drives = 1;
      if (sz == 0) begin e = 16'h0000; m_unf = 1; end
      else e = mdl.pop_front();
    end else if (STAT_EN && addr == BASE + 19'd1) begin
      drives = 1;
      e = {m_ovf, m_unf, sz == DEPTH, sz == 0, 3'b000, 9'(sz)};
      m_ovf = 0; m_unf = 0;
    end else if (STAT_EN && addr == BASE + 19'd2) begin
      drives = 1;
      e = 16'(sz);
    end
    if (drives) exp_q.push_back(e);
    r0 = oe_rises;
    xa = addr; zcs2 = 1'b0;
    @(posedge clk); #1 xrd = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #2;
      if (xd_oe) begin lat = i; break; end
    end
    repeat (6) @(posedge clk);
    #3 xrd = 1'b1; zcs2 = 1'b1;
    if (push_at_done) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (!xd_oe) begin seen = 1; break; end
      end
      chk("oe_fall_seen", seen, 1);
      push(pw);
      repeat (3) @(negedge clk);
    end else repeat (5) @(negedge clk);
    if (drives) begin
      chk("rd_latency", lat, 3);
      chk("drive_count", oe_rises - r0, 1);
    end else chk("no_drive", oe_rises - r0, 0);
  endtask

  function automatic logic [18:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return BASE;
      2:       return BASE + 19'(1 + $urandom_range(0, 1));
      default: return BASE + 19'd5;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; zcs2 = 1'b1; xrd = 1'b1; xa = '0;
    wr_en = 1'b0; wr_data = '0; clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst:xd_oe", xd_oe, 0);
    chk("rst:xd_out", xd_out, 0);
    chk("rst:full", fifo_full, 0);
    chk("rst:empty", fifo_empty, 1);
    chk("rst:ovf", ovf, 0);
    chk("rst:count", int'(rd_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    push(16'h1111); push(16'h2222); push(16'h3333);
    check_flags("t1_fill");
    for (int i = 0; i < 3; i++) begin
      dsp_read(BASE, 0, '0);
      check_flags("t1_read");
    end

    dsp_read(BASE, 0, '0);
    check_flags("t2_empty_read");
    dsp_read(BASE + 19'd1, 0, '0);
    dsp_read(BASE + 19'd1, 0, '0);
    dsp_read(BASE + 19'd2, 0, '0);
    check_flags("t2_status");

    for (int i = 0; i < DEPTH; i++) push(16'(i));
    check_flags("t3_full");
    push(16'hBEEF);
    check_flags("t3_ovf");
    dsp_read(BASE + 19'd2, 0, '0);
    dsp_read(BASE + 19'd1, 0, '0);
    for (int i = 0; i < DEPTH; i++) dsp_read(BASE, 0, '0);
    check_flags("t3_drained");

    do_clr();
    for (int i = 0; i < DEPTH; i++) push(16'($urandom));
    check_flags("t4_full");
    dsp_read(BASE, 1, 16'hA5C3);
    check_flags("t4_pop_push");
    for (int i = 0; i < DEPTH; i++) dsp_read(BASE, 0, '0);
    check_flags("t4_drained");

    dsp_read(BASE + 19'd5, 0, '0);
    for (int i = 0; i < 4; i++) push(16'($urandom));
    begin
      bit up = 0;
      exp_q.push_back(mdl[0]);
      xa = BASE; zcs2 = 1'b0;
      @(posedge clk); #1 xrd = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #2;
        if (xd_oe) begin up = 1; break; end
      end
      chk("t5_drive_up", up, 1);
      @(negedge clk); #2 rst_n = 1'b0;
      #1 chk("t5_oe_async_reset", xd_oe, 0);
      xrd = 1'b1; zcs2 = 1'b1;
      mdl.delete(); m_ovf = 0; m_unf = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_flags("t5_after_reset");
    end

    for (int i = 0; i < 10; i++) push(16'($urandom));
    check_flags("t6_ten");
    clr = 1'b1; wr_en = 1'b1; wr_data = 16'h7E7E;
    @(negedge clk);
    clr = 1'b0; wr_en = 1'b0;
    mdl.delete(); m_ovf = 0; m_unf = 0;
    check_flags("t6_clr");
    dsp_read(BASE, 0, '0);
    check_flags("t6_read");

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: begin
          int b = $urandom_range(1, 6);
          for (int k = 0; k < b; k++) push(16'($urandom));
        end
        3, 4, 5: dsp_read(rand_addr(), 0, '0);
        6:       dsp_read(BASE, 1, 16'($urandom));
        default: do_clr();
      endcase
      check_flags("rand");
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
